// File: rtl/im_loader.sv
// im_loader: streams instruction words from a host into IM by injecting
// one write token per free pipeline slot into the Ftc0->Ftc1 token path.
module im_loader #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [14:0]       count_i,
  input  logic              ins_valid_i,
  input  logic [33:0]       ins_i,
  output logic              ins_ready_o,
  input  logic              slot_free_i,
  output logic              tok_valid_o,
  output logic [15:0]       node_o,
  output logic [11:0]       gen_o,
  output logic [31:0]       opr0_o,
  output logic [31:0]       opr1_o,
  output logic [1:0]        mem_wen_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FILL_MAX = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [33:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       fill_q;
  logic [14:0]       count_q, accepted_q, issued_q;
  logic [ADDR_W-1:0] addr_q;
  logic              tok_valid_q;
  logic [ADDR_W-1:0] tok_addr_q;
  logic [33:0]       tok_word_q;
  logic              done_q, err_q;

  logic fifo_full, fifo_empty, push, pop, start_ok, last_issue;

  assign fifo_full   = (fill_q == FILL_MAX);
  assign fifo_empty  = (fill_q == '0);
  assign ins_ready_o = (state_q == S_LOAD) && !fifo_full && (accepted_q < count_q);
  assign push        = ins_valid_i && ins_ready_o;
  assign pop         = (state_q == S_LOAD) && !fifo_empty && slot_free_i;
  assign start_ok    = (state_q == S_IDLE) && start_i;
  assign last_issue  = pop && ((issued_q + 15'd1) == count_q);

  // Next-state logic for the load sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = (count_i == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (last_issue) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Word storage; contents are meaningless while fill is zero, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ins_i;
  end

  // Counters, FIFO pointers, registered token and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      count_q     <= '0;
      accepted_q  <= '0;
      issued_q    <= '0;
      addr_q      <= '0;
      tok_valid_q <= 1'b0;
      tok_addr_q  <= '0;
      tok_word_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tok_valid_q <= pop;
      tok_addr_q  <= pop ? addr_q : '0;
      tok_word_q  <= pop ? mem_q[rd_ptr_q] : '0;
      // done is the registered image of the DONE state, so it lands one
      // cycle after the final token and never overlaps it
      done_q      <= (state_q == S_DONE);
      if (start_ok) begin
        addr_q     <= base_addr_i;
        count_q    <= count_i;
        accepted_q <= '0;
        issued_q   <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fill_q     <= '0;
        err_q      <= 1'b0;
      end else begin
        if (start_i && (state_q != S_IDLE)) err_q <= 1'b1;
        if (push) begin
          wr_ptr_q   <= wr_ptr_q + PW'(1);
          accepted_q <= accepted_q + 15'd1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
          addr_q   <= addr_q + ADDR_W'(1);
          issued_q <= issued_q + 15'd1;
        end
        if (push && !pop)      fill_q <= fill_q + (PW+1)'(1);
        else if (pop && !push) fill_q <= fill_q - (PW+1)'(1);
      end
    end
  end

  assign tok_valid_o = tok_valid_q;
  assign node_o      = 16'(tok_addr_q);
  assign gen_o       = {10'b0, tok_word_q[33:32]};
  assign opr0_o      = tok_word_q[31:0];
  assign opr1_o      = '0;
  assign mem_wen_o   = {1'b0, tok_valid_q};
  assign busy_o      = (state_q == S_LOAD);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: the driver plans each load and queues the
// expected IM write tokens; an independent monitor checks every token.
module tb_im_loader;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst, start_i, ins_valid_i, slot_free_i;
  logic [13:0] base_addr_i;
  logic [14:0] count_i;
  logic [33:0] ins_i;
  logic        ins_ready_o, tok_valid_o, busy_o, done_o, err_o;
  logic [15:0] node_o;
  logic [11:0] gen_o;
  logic [31:0] opr0_o, opr1_o;
  logic [1:0]  mem_wen_o;

  always #5 clk = ~clk;

  im_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .count_i(count_i), .ins_valid_i(ins_valid_i), .ins_i(ins_i),
    .ins_ready_o(ins_ready_o), .slot_free_i(slot_free_i),
    .tok_valid_o(tok_valid_o), .node_o(node_o), .gen_o(gen_o),
    .opr0_o(opr0_o), .opr1_o(opr1_o), .mem_wen_o(mem_wen_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [15:0] node;
    logic [11:0] gen;
    logic [31:0] opr0;
  } tok_t;

  tok_t        exp_q[$];
  logic [33:0] feed_q[$];
  int checks = 0, failures = 0, tok_cnt = 0, acc_cnt = 0;
  bit rand_gaps = 0, rand_slot = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model: k-th word of a load goes to (base + k) mod 2^ADDR_W
  task automatic plan_load(input int base, input int cnt, input int extra);
    for (int k = 0; k < cnt + extra; k++) begin
      logic [33:0] w;
      w = {$urandom_range(0, 3), $urandom};
      feed_q.push_back(w);
      if (k < cnt) begin
        tok_t t;
        t.node = 16'((base + k) % (1 << ADDR_W));
        t.gen  = {10'b0, w[33:32]};
        t.opr0 = w[31:0];
        exp_q.push_back(t);
      end
    end
  endtask

  // One clock: record the handshake of the current cycle, then drive the next
  task automatic step();
    bit hs;
    hs = ins_valid_i && ins_ready_o && rst;
    @(posedge clk);
    @(negedge clk);
    if (hs) begin
      void'(feed_q.pop_front());
      acc_cnt++;
    end
    if (rand_slot) slot_free_i = ($urandom_range(0, 2) != 0);
    if (feed_q.size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
      ins_valid_i = 1'b1;
      ins_i       = feed_q[0];
    end else begin
      ins_valid_i = 1'b0;
      ins_i       = {$urandom_range(0, 3), $urandom};
    end
  endtask

  task automatic start_load(input int base, input int cnt);
    base_addr_i = 14'(base);
    count_i     = 15'(cnt);
    start_i     = 1'b1;
    acc_cnt     = 0;
    step();
    start_i = 1'b0;
    check("err_cleared_on_start", err_o, 0);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = done_o;
    end
    check("done_pulse", seen, 1);
    step();
    check("done_one_cycle", done_o, 0);
    feed_q.delete();
    ins_valid_i = 1'b0;
  endtask

  // Monitor: every token must match the head of the expected queue
  always @(negedge clk) begin : mon
    tok_t e;
    if (tok_valid_o) begin
      tok_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_token", tok_valid_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("tok_node", node_o, e.node);
        check("tok_gen", gen_o, e.gen);
        check("tok_opr0", opr0_o, e.opr0);
        check("tok_opr1", opr1_o, 0);
        check("tok_mem_wen", mem_wen_o, 2'b01);
      end
    end else begin
      check("idle_zero", |{node_o, gen_o, opr0_o, opr1_o, mem_wen_o}, 0);
    end
    if (done_o) begin
      check("done_no_token", tok_valid_o, 0);
      check("done_all_issued", exp_q.size(), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int tb0;
    rst = 1'b0; start_i = 1'b0; base_addr_i = '0; count_i = '0;
    ins_valid_i = 1'b0; ins_i = '0; slot_free_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", |{tok_valid_o, node_o, gen_o, opr0_o, opr1_o, mem_wen_o,
                             busy_o, done_o, err_o, ins_ready_o}, 0);
    rst = 1'b1;
    step();

    // Basic load with fixed words
    feed_q.push_back(34'h3_0000_0001);
    feed_q.push_back(34'h0_0000_0002);
    feed_q.push_back(34'h2_FFFF_FFFF);
    exp_q.push_back('{16'h0010, 12'h003, 32'h0000_0001});
    exp_q.push_back('{16'h0011, 12'h000, 32'h0000_0002});
    exp_q.push_back('{16'h0012, 12'h002, 32'hFFFF_FFFF});
    slot_free_i = 1'b1;
    start_load(16'h0010, 3);
    check("busy_in_load", busy_o, 1);
    wait_done(50);
    check("basic_accepted", acc_cnt, 3);

    // Backpressure: FIFO fills to depth with no free slots
    slot_free_i = 1'b0;
    plan_load(16'h0123, 6, 0);
    start_load(16'h0123, 6);
    repeat (10) step();
    check("bp_accepted", acc_cnt, DEPTH);
    check("bp_ready_low", ins_ready_o, 0);
    slot_free_i = 1'b1;
    wait_done(100);
    check("bp_total_accepted", acc_cnt, 6);

    // Address wrap
    plan_load(16'h3FFE, 4, 0);
    start_load(16'h3FFE, 4);
    wait_done(50);

    // Start while busy, and over-supply beyond count
    slot_free_i = 1'b0;
    plan_load(16'h0200, 3, 1);
    start_load(16'h0200, 3);
    step(); step();
    start_i = 1'b1; base_addr_i = 14'h1234; count_i = 15'd9;
    step();
    start_i = 1'b0;
    check("err_set", err_o, 1);
    check("err_load_continues", busy_o, 1);
    repeat (8) step();
    check("oversupply_accepted", acc_cnt, 3);
    check("oversupply_ready_low", ins_ready_o, 0);
    slot_free_i = 1'b1;
    wait_done(50);
    check("err_sticky", err_o, 1);

    // Zero count: done in the 2nd cycle after start, no ready, no token
    start_load(16'h0055, 0);
    check("zero_ready", ins_ready_o, 0);
    check("zero_done_early", done_o, 0);
    step();
    check("zero_done", done_o, 1);
    check("zero_ready2", ins_ready_o, 0);
    step();
    check("zero_done_end", done_o, 0);

    // Randomized loads
    rand_gaps = 1; rand_slot = 1;
    for (int n = 0; n < 6; n++) begin
      int b, c, x;
      b = int'($urandom_range(0, (1 << ADDR_W) - 1));
      c = int'($urandom_range(1, 12));
      x = int'($urandom_range(0, 2));
      plan_load(b, c, x);
      start_load(b, c);
      wait_done(600);
      check("rand_accepted", acc_cnt, c);
    end
    rand_gaps = 0; rand_slot = 0;

    // Reset mid-load after two of five tokens
    slot_free_i = 1'b0;
    plan_load(16'h0700, 5, 0);
    start_load(16'h0700, 5);
    repeat (8) step();
    tb0 = tok_cnt;
    slot_free_i = 1'b1;
    step(); step();
    slot_free_i = 1'b0;
    repeat (4) step();
    check("tokens_before_reset", tok_cnt - tb0, 2);
    rst = 1'b0;
    step();
    check("midload_reset_outputs", |{tok_valid_o, node_o, gen_o, opr0_o, opr1_o, mem_wen_o,
                                     busy_o, done_o, err_o, ins_ready_o}, 0);
    rst = 1'b1;
    exp_q.delete();
    feed_q.delete();
    plan_load(0, 0, 3);
    acc_cnt = 0;
    tb0 = tok_cnt;
    slot_free_i = 1'b1;
    repeat (10) step();
    check("post_reset_no_accept", acc_cnt, 0);
    check("post_reset_no_token", tok_cnt - tb0, 0);
    check("post_reset_idle", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
